// File: rtl/reg_select_decoder_pkg.sv
// reg_select_decoder_pkg: shared widths, register select codes and output bit indices
package reg_select_decoder_pkg;

    localparam int SEL_WIDTH = 4;
    localparam int OUT_WIDTH = 14;

    localparam logic [SEL_WIDTH-1:0] SEL_NONE    = 4'd0;
    localparam logic [SEL_WIDTH-1:0] SEL_IR      = 4'd1;
    localparam logic [SEL_WIDTH-1:0] SEL_MAR     = 4'd2;
    localparam logic [SEL_WIDTH-1:0] SEL_MDR     = 4'd3;
    localparam logic [SEL_WIDTH-1:0] SEL_PC      = 4'd4;
    localparam logic [SEL_WIDTH-1:0] SEL_AC      = 4'd5;
    localparam logic [SEL_WIDTH-1:0] SEL_T       = 4'd6;
    localparam logic [SEL_WIDTH-1:0] SEL_CENTERP = 4'd7;
    localparam logic [SEL_WIDTH-1:0] SEL_L       = 4'd8;
    localparam logic [SEL_WIDTH-1:0] SEL_J       = 4'd9;
    localparam logic [SEL_WIDTH-1:0] SEL_X       = 4'd10;
    localparam logic [SEL_WIDTH-1:0] SEL_COUNT   = 4'd11;
    localparam logic [SEL_WIDTH-1:0] SEL_K       = 4'd12;
    localparam logic [SEL_WIDTH-1:0] SEL_W       = 4'd13;
    localparam logic [SEL_WIDTH-1:0] SEL_H       = 4'd14;

    localparam int BIT_IR      = 0;
    localparam int BIT_MAR     = 1;
    localparam int BIT_MDR     = 2;
    localparam int BIT_PC      = 3;
    localparam int BIT_AC      = 4;
    localparam int BIT_T       = 5;
    localparam int BIT_CENTERP = 6;
    localparam int BIT_L       = 7;
    localparam int BIT_J       = 8;
    localparam int BIT_X       = 9;
    localparam int BIT_COUNT   = 10;
    localparam int BIT_K       = 11;
    localparam int BIT_W       = 12;
    localparam int BIT_H       = 13;

endpackage

// File: rtl/reg_select_decoder.sv
// reg_select_decoder: registered select code to one-hot register enable decoder
module reg_select_decoder
    import reg_select_decoder_pkg::*;
#(
    parameter int SEL_WIDTH = reg_select_decoder_pkg::SEL_WIDTH,
    parameter int OUT_WIDTH = reg_select_decoder_pkg::OUT_WIDTH
) (
    input  logic [SEL_WIDTH-1:0] sel,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 sel_err,
    input  logic                 clk,
    input  logic                 rst_n
);

    logic [OUT_WIDTH-1:0] dec;
    logic                 err;

    // code k lights bit k-1; code 0 and out-of-range codes light nothing
    always_comb begin
        dec = '0;
        for (int i = 0; i < OUT_WIDTH; i++) dec[i] = (sel == SEL_WIDTH'(i + 1));
        err = 32'(sel) > OUT_WIDTH;
    end

    // outputs are registered so no combinational path exists from sel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out     <= '0;
            sel_err <= 1'b0;
        end else begin
            out     <= dec;
            sel_err <= err;
        end
    end

endmodule

// File: tb/tb_reg_select_decoder.sv
// tb_reg_select_decoder: scoreboard bench for the registered one-hot select decoder
module tb_reg_select_decoder;
    import reg_select_decoder_pkg::*;

    typedef struct packed {
        logic [13:0] o;
        logic        e;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  sel;
    logic [13:0] out;
    logic        sel_err;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    reg_select_decoder dut (
        .sel    (sel),
        .out    (out),
        .sel_err(sel_err),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n === 1'b1) assert (!$isunknown(sel)) else $error("sel is X/Z while out of reset");
    end

    function automatic logic [13:0] ref_out(input logic [3:0] s);
        logic [13:0] one;
        one = 14'd1;
        return (s >= 4'd1 && s <= 4'd14) ? (one << (s - 4'd1)) : 14'd0;
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] s, input string tag);
        exp_t x;
        rst_n = r;
        sel   = s;
        x.o   = r ? ref_out(s) : 14'd0;
        x.e   = r ? (s > 4'd14) : 1'b0;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check({tag, ".out"}, 16'(out), 16'(x.o));
        check({tag, ".err"}, 16'(sel_err), 16'(x.e));
        check({tag, ".onehot"}, 16'($countones(out) <= 1), 16'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        sel   = 4'd0;

        step(1'b0, SEL_AC, "rst0");
        step(1'b0, SEL_AC, "rst1");
        check("rst_out_const", 16'(out), 16'h0000);
        step(1'b1, SEL_AC, "rel");
        check("rel_ac_const", 16'(out), 16'h0010);

        for (int k = 0; k < 16; k++) step(1'b1, 4'(k), "sweep");
        check("sweep15_err", 16'(sel_err), 16'd1);
        check("sweep15_out", 16'(out), 16'h0000);

        step(1'b1, SEL_MDR, "lat_a");
        check("lat_a_const", 16'(out), 16'h0004);
        sel = SEL_K;
        #3;
        check("lat_hold", 16'(out), 16'h0004);
        step(1'b1, SEL_K, "lat_b");
        check("lat_b_const", 16'(out), 16'h0800);

        step(1'b1, SEL_H, "mid_h");
        check("mid_h_const", 16'(out), 16'h2000);
        step(1'b0, SEL_H, "mid_rst");
        check("mid_rst_const", 16'(out), 16'h0000);
        step(1'b1, SEL_H, "mid_rel");
        check("mid_rel_const", 16'(out), 16'h2000);

        for (int n = 0; n < 1000; n++)
            step($urandom_range(99) >= 5, 4'($urandom_range(15)), "rand");

        check("sb_empty", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_select_decoder.md
Name: reg_select_decoder

Overview:
- Registered 4-bit to 14-bit one-hot register-select decoder for the processor datapath.
- The controller instantiates two copies: one maps the IR write-register field to the per-register write enables; the other maps the IR read-register field to the per-register read enables.
- Output bit order, MSB to LSB, is H, W, K, Count, X, J, L, CenterP, T, AC, PC, MDR, MAR, IR.
- Code 0 means "no register selected".

Parameters:
- SEL_WIDTH, 4, width of the select code.
- OUT_WIDTH, 14, number of one-hot outputs. Legal range is 1 to 2**SEL_WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- sel  input  SEL_WIDTH  register select code, first positional port.
- out  output  OUT_WIDTH  registered one-hot select, second positional port.
- sel_err  output  1  registered flag: the last sampled code was out of range.

Interface (already decided): one clock; reset is synchronous and active-low.

Behaviour:
- Reset: on a rising clk edge with rst_n=0, out <= 0 and sel_err <= 0. Reset has priority over everything else.
- Decode, on a rising clk edge with rst_n=1:
  - sel=0: out <= 0, sel_err <= 0 (no register selected).
  - sel=k, with 1 <= k <= OUT_WIDTH: out <= one-hot with only bit k-1 set; sel_err <= 0.
  - Default mapping is 1=IR, 2=MAR, 3=MDR, 4=PC, 5=AC, 6=T, 7=CenterP, 8=L, 9=J, 10=X, 11=Count, 12=K, 13=W, 14=H.
  - sel > OUT_WIDTH (code 15 at default width): out <= 0, sel_err <= 1.
- Latency: exactly 1 cycle from sel to out and sel_err. There is no combinational path from sel to any output.
- Invariant: popcount(out) <= 1 in every cycle. out is never X after the first reset.
- No enable and no handshake: sel is sampled every cycle. A hold is obtained by holding sel.
- Reset mid-stream: a sel applied in a cycle whose edge sees rst_n=0 is discarded. The first decoded value appears on the first edge with rst_n=1.
- Back-to-back changes of sel: each edge reflects only the sel value sampled at that edge. No glitch or overlap of two bits at any time.
- Between 1 and 14, X/Z on sel is a don't-care for synthesis. The bench asserts sel is never X/Z when rst_n=1.

Decomposition:
- Shared package holds:
  - OUT_WIDTH=14 and SEL_WIDTH=4 constants.
  - Named constants for each register code: SEL_NONE=0, SEL_IR=1, SEL_MAR=2, SEL_MDR=3, SEL_PC=4, SEL_AC=5, SEL_T=6, SEL_CENTERP=7, SEL_L=8, SEL_J=9, SEL_X=10, SEL_COUNT=11, SEL_K=12, SEL_W=13, SEL_H=14.
  - Named bit indices for the output vector.
- No sub-module is needed.
- Optionally split into a pure combinational decode function in the package plus the output register in this module. The function is reusable by the bench as a reference model.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with sel=5 -> out=14'h0000, sel_err=0. Release rst_n, keep sel=5 -> after 1 edge out=14'h0010 (AC).
- Full sweep: apply sel 0..15 on consecutive edges -> out sequence 0, 0x0001, 0x0002, 0x0004 ... 0x2000 each one cycle later. Code 15 gives out=0 and sel_err=1. sel_err is 0 for all other codes.
- Latency check: change sel 3->12 between edges -> out stays 0x0004 until the next edge, then becomes 0x0800 (K). No intermediate value.
- Synchronous reset mid-operation: sel=14 with out=0x2000, drive rst_n=0 for one edge -> out=0 on that edge. rst_n=1 next edge -> out=0x2000 again.
- Random: 1000 cycles of random sel with 5% random reset pulses -> out equals the reference function of the previous-cycle sel. popcount(out)<=1 always. sel_err equals (previous sel > 14).
